// File: rtl/readout_sequencer_pkg.sv
// Shared frame geometry, derived widths and FSM state encoding for the readout sequencer.
// Widths are derived from the frame geometry so that changing N_WORDS or WORD_W is enough to retarget the block.
package readout_sequencer_pkg;

    localparam int N_WORDS = 16;
    localparam int WORD_W  = 12;
    localparam int SEL_W   = $clog2(N_WORDS);
    localparam int CNT_W   = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/readout_sequencer_next_idx.sv
// Combinational search for the lowest set mask bit above the current word index.
// Zero latency. No flow control: o_found is low when no later word is enabled.
module next_enabled_idx
    import readout_sequencer_pkg::*;
#(
    parameter int N     = N_WORDS,
    parameter int IDX_W = SEL_W
) (
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_idx,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the last hit written is the smallest qualifying index.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i] && (IDX_W'(i) > i_idx)) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Frame sequencer: on a trigger rising edge, loads and shifts out each enabled word MSB first, then clears.
// LOAD one cycle after the edge, 13 cycles per word; edges while busy are dropped and flagged as overrun.
module readout_sequencer #(
    parameter int N_WORDS = readout_sequencer_pkg::N_WORDS,
    parameter int WORD_W  = readout_sequencer_pkg::WORD_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_trigger,
    input  logic [N_WORDS-1:0]         i_ch_mask,
    input  logic                       i_clear_overrun,
    output logic [$clog2(N_WORDS)-1:0] o_sel,
    output logic                       o_sl,
    output logic                       o_sout_valid,
    output logic                       o_frame_start,
    output logic                       o_frame_end,
    output logic                       o_busy,
    output logic                       o_clr,
    output logic                       o_overrun
);

    import readout_sequencer_pkg::*;

    localparam int                  SEL_BITS = $clog2(N_WORDS);
    localparam int                  CNT_BITS = $clog2(WORD_W);
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WORD_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_trig_q;
    logic [N_WORDS-1:0]  r_mask;
    logic [N_WORDS-1:0]  w_mask_nxt;
    logic [SEL_BITS-1:0] r_sel;
    logic [SEL_BITS-1:0] w_sel_nxt;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic                r_overrun;
    logic                w_edge;
    logic                w_busy;
    logic                w_found;
    logic [SEL_BITS-1:0] w_next_idx;

    next_enabled_idx #(
        .N     (N_WORDS),
        .IDX_W (SEL_BITS)
    ) u_next_idx (
        .i_mask  (r_mask),
        .i_idx   (r_sel),
        .o_idx   (w_next_idx),
        .o_found (w_found)
    );

    assign w_edge = i_trigger & ~r_trig_q;
    assign w_busy = (r_state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_trig_q  <= 1'b0;
            r_mask    <= N_WORDS'(1);
            r_sel     <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trig_q <= i_trigger;
            r_mask   <= w_mask_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            // A new overrun event takes priority over a simultaneous clear request.
            if (w_edge && w_busy) begin
                r_overrun <= 1'b1;
            end else if (i_clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        o_sl          = 1'b1;
        o_sout_valid  = 1'b0;
        o_frame_start = 1'b0;
        o_frame_end   = 1'b0;
        o_clr         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sel_nxt = '0;
                w_cnt_nxt = '0;
                if (w_edge) begin
                    w_state_nxt = ST_LOAD;
                    // Word 0 carries the time stamp and is always sent.
                    w_mask_nxt  = i_ch_mask | N_WORDS'(1);
                end
            end
            ST_LOAD: begin
                o_frame_start = (r_sel == '0);
                w_cnt_nxt     = '0;
                w_state_nxt   = ST_SHIFT;
            end
            ST_SHIFT: begin
                o_sl         = 1'b0;
                o_sout_valid = 1'b1;
                w_cnt_nxt    = r_cnt + 1'b1;
                if (r_cnt == LAST_BIT) begin
                    if (w_found) begin
                        w_state_nxt = ST_LOAD;
                        w_sel_nxt   = w_next_idx;
                    end else begin
                        w_state_nxt = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                o_clr       = 1'b1;
                o_frame_end = 1'b1;
                w_sel_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_sel     = r_sel;
    assign o_busy    = w_busy;
    assign o_overrun = r_overrun;

endmodule
